// File: rtl/sme_stream_pkg.sv
// Shared widths and types for the string-matching engine data stream.
package sme_stream_pkg;

    localparam int SYMBOL_W             = 8;
    localparam int DEF_SYMBOLS_PER_BEAT = 64;
    localparam int DEF_OUT_SYMBOLS      = 16;
    localparam int DEF_CHUNK_W          = DEF_OUT_SYMBOLS * SYMBOL_W;

    typedef logic [DEF_CHUNK_W-1:0] chunk_t;

endpackage

// File: rtl/fifo_beat_serializer.sv
// Splits full-width FIFO beats into RATIO narrower chunks, LS chunk first,
// using one hold register and a chunk index; full rate with two-way backpressure.
module fifo_beat_serializer
    import sme_stream_pkg::*;
#(
    parameter int SYMBOLS_PER_BEAT = DEF_SYMBOLS_PER_BEAT,
    parameter int BITS_PER_SYMBOL  = SYMBOL_W,
    parameter int OUT_SYMBOLS      = DEF_OUT_SYMBOLS
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        clear,
    input  logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] in_data,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [OUT_SYMBOLS*BITS_PER_SYMBOL-1:0]      out_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_last,
    output logic [31:0]                                 beats_in,
    output logic [31:0]                                 chunks_out
);

    localparam int RATIO = SYMBOLS_PER_BEAT / OUT_SYMBOLS;
    localparam int OUT_W = OUT_SYMBOLS * BITS_PER_SYMBOL;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (SYMBOLS_PER_BEAT % OUT_SYMBOLS != 0) begin : g_bad_ratio
        $error("SYMBOLS_PER_BEAT must be a multiple of OUT_SYMBOLS");
    end

    logic [RATIO-1:0][OUT_W-1:0] hold_data;
    logic                        hold_valid;
    logic [IDX_W-1:0]            idx;
    logic                        is_last;
    logic                        in_xfer;
    logic                        out_xfer;

    // clear blocks both handshakes so a flushed cycle never counts a transfer
    assign is_last  = (idx == LAST_IDX);
    assign in_ready = !clear && (!hold_valid || (out_ready && is_last));
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = hold_valid && out_ready && !clear;

    assign out_valid = hold_valid;
    assign out_data  = hold_data[idx];
    assign out_last  = hold_valid && is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            idx        <= '0;
        end else if (clear) begin
            hold_valid <= 1'b0;
            idx        <= '0;
        end else if (in_xfer) begin
            hold_data  <= in_data;
            hold_valid <= 1'b1;
            idx        <= '0;
        end else if (out_xfer) begin
            if (is_last) begin
                hold_valid <= 1'b0;
                idx        <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_in   <= '0;
            chunks_out <= '0;
        end else begin
            if (in_xfer)  beats_in   <= beats_in + 32'd1;
            if (out_xfer) chunks_out <= chunks_out + 32'd1;
        end
    end

endmodule
